// File: rtl/pipeline_hazard_ctrl.sv
// Stall/bubble sequencing for the 5-stage core: load-use, branch flush, memory busy.
// Optional perf counters are compiled in with `define HAZARD_PERF_CNT_EN.
module pipeline_hazard_ctrl #(
  parameter int flush_cycles_p   = 2,
  parameter int reg_addr_width_p = 5
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        dec_v_i,
  input  logic [reg_addr_width_p-1:0] dec_rs1_i,
  input  logic                        dec_rs1_v_i,
  input  logic [reg_addr_width_p-1:0] dec_rs2_i,
  input  logic                        dec_rs2_v_i,
  input  logic [reg_addr_width_p-1:0] dec_rd_i,
  input  logic                        dec_rd_w_v_i,
  input  logic                        dec_load_v_i,
  input  logic                        br_taken_i,
  input  logic                        mem_busy_i,
  output logic                        stall_v_o,
  output logic                        bubble_v_o,
  output logic                        ex_bubble_v_o,
  output logic                        redirect_v_o,
  output logic [1:0]                  state_o
`ifdef HAZARD_PERF_CNT_EN
  ,output logic [31:0]                stall_cnt_o,
  output logic [31:0]                 flush_cnt_o
`endif
);

  // state    | meaning
  // RUN      | normal issue, load-use detection active
  // FLUSH    | injecting post-branch bubbles, cnt_r bubbles still owed
  // MEM_WAIT | memory busy, pipe frozen, saved_r holds state to resume
  typedef enum logic [1:0] {
    RUN      = 2'd0,
    FLUSH    = 2'd1,
    MEM_WAIT = 2'd2
  } state_e;

  localparam logic [2:0] cnt_init_lp = 3'(flush_cycles_p - 1);

  state_e                        state_r;
  state_e                        saved_r;
  state_e                        eval_state;
  logic [2:0]                    cnt_r;
  logic                          ex_load_v_r;
  logic [reg_addr_width_p-1:0]   ex_load_rd_r;
  logic                          hazard;

  // Leaving MEM_WAIT resumes the saved state within the same cycle.
  assign eval_state = (state_r == MEM_WAIT) ? saved_r : state_r;

  assign hazard = dec_v_i & ex_load_v_r & (ex_load_rd_r != '0) &
                  ((dec_rs1_v_i & (dec_rs1_i == ex_load_rd_r)) |
                   (dec_rs2_v_i & (dec_rs2_i == ex_load_rd_r)));

  always_comb begin
    stall_v_o     = 1'b0;
    bubble_v_o    = 1'b0;
    ex_bubble_v_o = 1'b0;
    redirect_v_o  = 1'b0;
    if (mem_busy_i) begin
      stall_v_o = 1'b1;
    end else if (br_taken_i) begin
      redirect_v_o  = 1'b1;
      bubble_v_o    = 1'b1;
      ex_bubble_v_o = 1'b1;
    end else if (eval_state == FLUSH) begin
      bubble_v_o    = 1'b1;
      ex_bubble_v_o = 1'b1;
    end else if (hazard) begin
      stall_v_o     = 1'b1;
      ex_bubble_v_o = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_r      <= RUN;
      saved_r      <= RUN;
      cnt_r        <= '0;
      ex_load_v_r  <= 1'b0;
      ex_load_rd_r <= '0;
    end else if (mem_busy_i) begin
      state_r <= MEM_WAIT;
      if (state_r != MEM_WAIT) saved_r <= state_r;
    end else begin
      if (br_taken_i) begin
        if (flush_cycles_p > 1) begin
          state_r <= FLUSH;
          cnt_r   <= cnt_init_lp;
        end else begin
          state_r <= RUN;
          cnt_r   <= '0;
        end
      end else if (eval_state == FLUSH) begin
        if (cnt_r <= 3'd1) begin
          state_r <= RUN;
          cnt_r   <= '0;
        end else begin
          state_r <= FLUSH;
          cnt_r   <= cnt_r - 3'd1;
        end
      end else begin
        state_r <= RUN;
      end
      ex_load_v_r  <= ~ex_bubble_v_o & dec_v_i & dec_load_v_i & dec_rd_w_v_i &
                      (dec_rd_i != '0);
      ex_load_rd_r <= dec_rd_i;
    end
  end

  assign state_o = state_r;

`ifdef HAZARD_PERF_CNT_EN
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stall_cnt_o <= '0;
      flush_cnt_o <= '0;
    end else begin
      if (stall_v_o)  stall_cnt_o <= stall_cnt_o + 32'd1;
      if (bubble_v_o) flush_cnt_o <= flush_cnt_o + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: two instances (flush 2 and 3) against a bubble-debt model.
module tb_pipeline_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       dec_v, rs1_v, rs2_v, rd_w, ld, br, busy;
  logic [4:0] rs1, rs2, rd;
  logic [1:0] stall, bubble, exb, redir;
  logic [1:0] st0, st1;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] scnt [2];
  logic [31:0] fcnt [2];
`endif

  int checks = 0;
  int failures = 0;

  // model: flush bubbles still owed, freeze flag, load in execute, perf tallies
  int         owed   [2];
  bit         frozen [2];
  bit         ldv    [2];
  logic [4:0] ldrd   [2];
  int         n_stall[2];
  int         n_bub  [2];

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(.flush_cycles_p(2), .reg_addr_width_p(5)) dut2 (
    .clk_i(clk), .rst_i(rst), .dec_v_i(dec_v),
    .dec_rs1_i(rs1), .dec_rs1_v_i(rs1_v), .dec_rs2_i(rs2), .dec_rs2_v_i(rs2_v),
    .dec_rd_i(rd), .dec_rd_w_v_i(rd_w), .dec_load_v_i(ld),
    .br_taken_i(br), .mem_busy_i(busy),
    .stall_v_o(stall[0]), .bubble_v_o(bubble[0]), .ex_bubble_v_o(exb[0]),
    .redirect_v_o(redir[0]), .state_o(st0)
`ifdef HAZARD_PERF_CNT_EN
    , .stall_cnt_o(scnt[0]), .flush_cnt_o(fcnt[0])
`endif
  );

  pipeline_hazard_ctrl #(.flush_cycles_p(3), .reg_addr_width_p(5)) dut3 (
    .clk_i(clk), .rst_i(rst), .dec_v_i(dec_v),
    .dec_rs1_i(rs1), .dec_rs1_v_i(rs1_v), .dec_rs2_i(rs2), .dec_rs2_v_i(rs2_v),
    .dec_rd_i(rd), .dec_rd_w_v_i(rd_w), .dec_load_v_i(ld),
    .br_taken_i(br), .mem_busy_i(busy),
    .stall_v_o(stall[1]), .bubble_v_o(bubble[1]), .ex_bubble_v_o(exb[1]),
    .redirect_v_o(redir[1]), .state_o(st1)
`ifdef HAZARD_PERF_CNT_EN
    , .stall_cnt_o(scnt[1]), .flush_cnt_o(fcnt[1])
`endif
  );

  function automatic int fp(input int k);
    return (k == 0) ? 2 : 3;
  endfunction

  function automatic string tagk(input string s, input int k);
    return $sformatf("%s_fp%0d", s, fp(k));
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    if (obs !== exp_v) begin
      failures++;
      $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp_v, $time);
    end
  endtask

  task automatic exp_out(input int k, output bit es, output bit eb, output bit ee, output bit er);
    es = 0; eb = 0; ee = 0; er = 0;
    if (busy) es = 1;
    else if (br) begin er = 1; eb = 1; ee = 1; end
    else if (owed[k] > 0) begin eb = 1; ee = 1; end
    else if (dec_v && ldv[k] && ldrd[k] != 0 &&
             ((rs1_v && rs1 == ldrd[k]) || (rs2_v && rs2 == ldrd[k]))) begin
      es = 1; ee = 1;
    end
  endtask

  // Inputs are set at the negedge before calling; returns at the next negedge.
  task automatic run_cycle();
    bit es [2];
    bit eb [2];
    bit ee [2];
    bit er [2];
    #1;
    for (int k = 0; k < 2; k++) begin
      exp_out(k, es[k], eb[k], ee[k], er[k]);
      if (!rst) begin
        chk(tagk("stall", k),    32'(stall[k]),  32'(es[k]));
        chk(tagk("bubble", k),   32'(bubble[k]), 32'(eb[k]));
        chk(tagk("ex_bubble", k), 32'(exb[k]),   32'(ee[k]));
        chk(tagk("redirect", k), 32'(redir[k]),  32'(er[k]));
      end
    end
    @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        owed[k] = 0; frozen[k] = 0; ldv[k] = 0; ldrd[k] = 0;
        n_stall[k] = 0; n_bub[k] = 0;
      end else begin
        n_stall[k] += int'(es[k]);
        n_bub[k]   += int'(eb[k]);
        if (busy) frozen[k] = 1;
        else begin
          frozen[k] = 0;
          if (br) owed[k] = fp(k) - 1;
          else if (owed[k] > 0) owed[k]--;
          ldv[k]  = !ee[k] && dec_v && ld && rd_w && rd != 0;
          ldrd[k] = rd;
        end
      end
    end
    #1;
    for (int k = 0; k < 2; k++) begin
      chk(tagk("state", k), 32'((k == 0) ? st0 : st1),
          frozen[k] ? 32'd2 : (owed[k] > 0 ? 32'd1 : 32'd0));
`ifdef HAZARD_PERF_CNT_EN
      chk(tagk("stall_cnt", k), scnt[k], 32'(n_stall[k]));
      chk(tagk("flush_cnt", k), fcnt[k], 32'(n_bub[k]));
`endif
    end
    @(negedge clk);
  endtask

  task automatic idle();
    rst = 0; dec_v = 0; rs1 = 0; rs1_v = 0; rs2 = 0; rs2_v = 0;
    rd = 0; rd_w = 0; ld = 0; br = 0; busy = 0;
  endtask

  task automatic issue_load(input logic [4:0] r);
    idle(); dec_v = 1; ld = 1; rd_w = 1; rd = r;
  endtask

  initial begin
    for (int k = 0; k < 2; k++) begin
      owed[k] = 0; frozen[k] = 0; ldv[k] = 0; ldrd[k] = 0; n_stall[k] = 0; n_bub[k] = 0;
    end
    idle();
    rst = 1;
    @(negedge clk);
    run_cycle();
    run_cycle();
    idle();
    run_cycle();

    // load rd=5 then consumer on rs1, held for a second decode cycle
    issue_load(5'd5); run_cycle();
    idle(); dec_v = 1; rs1 = 5'd5; rs1_v = 1; run_cycle();
    run_cycle();
    // load to x0 then consumer on rs2=0
    issue_load(5'd0); run_cycle();
    idle(); dec_v = 1; rs2 = 5'd0; rs2_v = 1; run_cycle();
    // both sources match: one stall only
    issue_load(5'd7); run_cycle();
    idle(); dec_v = 1; rs1 = 5'd7; rs1_v = 1; rs2 = 5'd7; rs2_v = 1; run_cycle();
    run_cycle();
    // single branch
    idle(); br = 1; run_cycle();
    idle(); for (int i = 0; i < 4; i++) run_cycle();
    // branch again on the following cycle
    br = 1; run_cycle(); run_cycle();
    idle(); for (int i = 0; i < 4; i++) run_cycle();
    // busy during flush with branch held, then branch accepted
    br = 1; run_cycle();
    idle(); run_cycle();
    busy = 1; br = 1;
    for (int i = 0; i < 3; i++) run_cycle();
    busy = 0; run_cycle();
    idle(); for (int i = 0; i < 4; i++) run_cycle();
    // reset in the middle of a flush
    br = 1; run_cycle();
    idle(); rst = 1; run_cycle();
    idle(); run_cycle();

    for (int n = 0; n < 1500; n++) begin
      idle();
      rst   = ($urandom_range(0, 99) < 2);
      dec_v = ($urandom_range(0, 3) != 0);
      rs1   = 5'($urandom_range(0, 3));
      rs2   = 5'($urandom_range(0, 3));
      rd    = 5'($urandom_range(0, 3));
      rs1_v = $urandom_range(0, 1) == 1;
      rs2_v = $urandom_range(0, 1) == 1;
      rd_w  = ($urandom_range(0, 3) != 0);
      ld    = $urandom_range(0, 1) == 1;
      br    = ($urandom_range(0, 9) == 0);
      busy  = ($urandom_range(0, 9) < 2);
      run_cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
